tx_rd_req_tlp_gen: RTL and testbench
====================================

Name: tx_rd_req_tlp_gen

Overview:
- Converts chunk-read requests (read_chunk / huge_page_addr_read_from / qwords_to_rd) from the TX huge-page-to-BRAM stage into PCIe Memory Read request TLPs on the TRN transmit interface.
- Splits each chunk at the negotiated max read request size and at 4KB boundaries.
- Pulses read_chunk_ack once every TLP of the chunk has been accepted by the core.

Parameters:
- TAG_WIDTH, 5, number of low tag bits used; upper tag bits are driven 0.
- MAX_QW_CAP, 64, maximum qwords per request TLP regardless of cfg_max_rd_req_size.

Ports:
- trn_clk  in  1  TRN clock; all logic is synchronous to it.
- reset_n  in  1  asynchronous, active-low reset.
- read_chunk  in  1  level request; held high until read_chunk_ack is seen.
- huge_page_addr_read_from  in  64  byte address of the chunk; bits [2:0] are ignored (QW aligned).
- qwords_to_rd  in  9  chunk length in qwords, 0..511.
- read_chunk_ack  out  1  one-cycle pulse: chunk fully issued.
- cfg_completer_id  in  16  requester ID {bus,dev,fn}.
- cfg_max_rd_req_size  in  3  PCIe MRRS encoding, 128<<n bytes.
- trn_td  out  64  TX data; DW0 in [63:32].
- trn_trem_n  out  8  0x00 = both DWs valid; 0x0F = upper DW only.
- trn_tsof_n  out  1  start of frame, active low.
- trn_teof_n  out  1  end of frame, active low.
- trn_tsrc_rdy_n  out  1  source ready, active low.
- trn_tsrc_dsc_n  out  1  discontinue; constant 1.
- trn_tdst_rdy_n  in  1  core ready, active low.

Behaviour:
- Reset values: trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n = 1; trn_td = 0; trn_trem_n = 0x00; read_chunk_ack = 0; tag counter = 0; FSM = IDLE.
- Reset mid-TLP aborts immediately with no further beats. The core is expected to discard the partial frame.
- IDLE:
  - If read_chunk=1, latch addr = {huge_page_addr_read_from[63:3], 3'b000}, rem = qwords_to_rd, and mrrs_qw = min(16<<cfg_max_rd_req_size, MAX_QW_CAP). Encodings >= 3 give 64.
  - If rem = 0, go to ACK. Otherwise go to CALC.
- CALC (1 cycle):
  - to4k = 512 - addr[11:3].
  - len_qw = min(rem, mrrs_qw, to4k).
  - fmt4 = (addr[63:32] != 0).
  - Go to HDR0.
- HDR0: drive trn_tsrc_rdy_n=0, trn_tsof_n=0, and trn_td = {DW0, DW1}.
  - DW0 = {1'b0, fmt4 ? 2'b01 : 2'b00, 5'b00000, 8'h00, 6'h00, length_dw}, where length_dw = 2*len_qw (10 bits; all fields TC/TD/EP/attr = 0).
  - DW1 = {cfg_completer_id, tag (8 bits, zero-extended), 4'hF, 4'hF}.
  - Advance to HDR1 on the cycle trn_tdst_rdy_n=0.
- HDR1: trn_tsof_n=1, trn_teof_n=0.
  - If fmt4: trn_td = {addr[63:32], addr[31:2], 2'b00}, trn_trem_n = 0x00.
  - Else: trn_td = {addr[31:2], 2'b00, 32'h0}, trn_trem_n = 0x0F.
  - On acceptance: addr += len_qw*8, rem -= len_qw, tag += 1 (wraps at 2^TAG_WIDTH to 0).
  - Then go to ACK if the new rem = 0, else CALC. trn_tsrc_rdy_n deasserts in CALC.
- Backpressure: while trn_tdst_rdy_n=1, every TX output holds its value and no state advances.
- ACK: read_chunk_ack=1 for exactly one cycle, then RELEASE.
- RELEASE: wait for read_chunk=0, then IDLE. This prevents re-issuing a stale request.
- Latency: read_chunk high in IDLE to first SOF beat = 2 cycles with no backpressure. Last EOF acceptance to ack = 1 cycle.
- Input values change while a chunk is in progress are ignored; only latched values are used.
- Exactly one TLP is in flight; the next TLP starts no earlier than 1 cycle after the previous EOF.

Test Plan:
- Addr 0x0000_0001_2345_6000, qwords 64, mrrs 2, id 0x0100, core always ready:
  - one TLP: QW0 0x20000080_010000FF (sof), QW1 0x00000001_23456000 (eof, trem_n 0x00);
  - read_chunk_ack 1 cycle after QW1.
- Addr 0x0000_0000_4000_0000, qwords 64, mrrs 0:
  - four 3DW TLPs, DW0 0x00000020, tags 0..3;
  - QW1 upper DW = 0x40000000, 0x40000080, 0x40000100, 0x40000180; trn_trem_n 0x0F;
  - single ack after the fourth.
- Addr 0x0000_0000_8000_0F00, qwords 64, mrrs 2 (4KB split):
  - TLP1 length 0x040 at 0x80000F00;
  - TLP2 length 0x040 at 0x80001000.
- trn_tdst_rdy_n held high 5 cycles during HDR0 and again during HDR1:
  - trn_td, trn_tsof_n, trn_teof_n, trn_trem_n stable throughout;
  - exactly 2 beats counted.
- qwords_to_rd = 0: no TX activity; ack 1 cycle after IDLE sample. read_chunk held high 10 cycles after ack: no second ack.
- 33 back-to-back 128B TLPs: tag sequence 0..31 then 0.
- reset_n asserted during HDR1: next cycle all TX outputs at reset values; after release the first TLP carries tag 0.

Source files
------------

// File: rtl/tx_rd_req_tlp_gen.sv
// tx_rd_req_tlp_gen: turns chunk-read requests into PCIe Memory Read request
// TLPs on the TRN transmit interface. Each chunk is split at the max read
// request size and at 4KB boundaries. read_chunk_ack pulses once the last TLP
// of the chunk has been accepted by the core.
//
// TRN handshake: a beat transfers on a rising edge where both trn_tsrc_rdy_n
// and trn_tdst_rdy_n are low. While trn_tdst_rdy_n is high, every TX output
// holds its value and the FSM does not advance.
module tx_rd_req_tlp_gen #(
  parameter int TAG_WIDTH  = 5,
  parameter int MAX_QW_CAP = 64
) (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic        read_chunk,
  input  logic [63:0] huge_page_addr_read_from,
  input  logic [8:0]  qwords_to_rd,
  output logic        read_chunk_ack,
  input  logic [15:0] cfg_completer_id,
  input  logic [2:0]  cfg_max_rd_req_size,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output logic        trn_tsrc_dsc_n,
  input  logic        trn_tdst_rdy_n,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC    = 3'd1,
    S_HDR0    = 3'd2,
    S_HDR1    = 3'd3,
    S_ACK     = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [63:0]          addr_q, addr_d;
  logic [9:0]           rem_q, rem_d;
  logic [9:0]           mrrs_q, mrrs_d;
  logic [9:0]           len_q, len_d;
  logic                 fmt4_q, fmt4_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;

  logic [9:0]           mrrs_sel;
  logic [9:0]           to4k;
  logic [9:0]           len_min;
  logic [7:0]           tag8;
  logic [31:0]          dw0;
  logic [31:0]          dw1;

  assign trn_tsrc_dsc_n = 1'b1;
  assign dbg_state      = state_q;

  // Request size in qwords from the MRRS encoding, clamped to the per-TLP cap.
  always_comb begin
    mrrs_sel = (cfg_max_rd_req_size >= 3'd3) ? 10'd64 : (10'd16 << cfg_max_rd_req_size);
    if (mrrs_sel > 10'(MAX_QW_CAP)) mrrs_sel = 10'(MAX_QW_CAP);
  end

  // Next TLP length: smallest of remaining qwords, MRRS and distance to 4KB.
  always_comb begin
    to4k    = 10'd512 - {1'b0, addr_q[11:3]};
    len_min = rem_q;
    if (mrrs_q < len_min) len_min = mrrs_q;
    if (to4k < len_min)   len_min = to4k;
  end

  // Header dwords built from latched chunk state and the live requester ID.
  always_comb begin
    tag8                 = 8'h00;
    tag8[TAG_WIDTH-1:0]  = tag_q;
    dw0 = {1'b0, (fmt4_q ? 2'b01 : 2'b00), 5'b00000, 8'h00, 6'h00, len_q[8:0], 1'b0};
    dw1 = {cfg_completer_id, tag8, 4'hF, 4'hF};
  end

  // Next-state, datapath updates and TRN outputs.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    rem_d          = rem_q;
    mrrs_d         = mrrs_q;
    len_d          = len_q;
    fmt4_d         = fmt4_q;
    tag_d          = tag_q;
    trn_td         = 64'h0;
    trn_trem_n     = 8'h00;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    read_chunk_ack = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read_chunk) begin
          addr_d  = huge_page_addr_read_from & ~64'h7;
          rem_d   = {1'b0, qwords_to_rd};
          mrrs_d  = mrrs_sel;
          state_d = (qwords_to_rd == 9'd0) ? S_ACK : S_CALC;
        end
      end
      S_CALC: begin
        len_d   = len_min;
        fmt4_d  = (addr_q[63:32] != 32'h0);
        state_d = S_HDR0;
      end
      S_HDR0: begin
        trn_tsrc_rdy_n = 1'b0;
        trn_tsof_n     = 1'b0;
        trn_td         = {dw0, dw1};
        if (!trn_tdst_rdy_n) state_d = S_HDR1;
      end
      S_HDR1: begin
        trn_tsrc_rdy_n = 1'b0;
        trn_teof_n     = 1'b0;
        if (fmt4_q) begin
          trn_td     = {addr_q[63:32], addr_q[31:2], 2'b00};
          trn_trem_n = 8'h00;
        end else begin
          trn_td     = {addr_q[31:2], 2'b00, 32'h0};
          trn_trem_n = 8'h0F;
        end
        if (!trn_tdst_rdy_n) begin
          addr_d  = addr_q + {51'd0, len_q, 3'b000};
          rem_d   = rem_q - len_q;
          tag_d   = tag_q + TAG_WIDTH'(1);
          state_d = (rem_q == len_q) ? S_ACK : S_CALC;
        end
      end
      S_ACK: begin
        read_chunk_ack = 1'b1;
        state_d        = S_RELEASE;
      end
      S_RELEASE: begin
        // Wait for the requester to drop its level request before rearming.
        if (!read_chunk) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any TLP in progress.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= 64'h0;
      rem_q   <= 10'd0;
      mrrs_q  <= 10'd0;
      len_q   <= 10'd0;
      fmt4_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      mrrs_q  <= mrrs_d;
      len_q   <= len_d;
      fmt4_q  <= fmt4_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_tx_rd_req_tlp_gen.sv
// Directed bench for tx_rd_req_tlp_gen: per-scenario tasks with inline checks
// against hand-computed TLP beats, a beat/ack monitor, and a final report.
module tb_tx_rd_req_tlp_gen;

  logic        trn_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        read_chunk = 1'b0;
  logic [63:0] addr_in = 64'h0;
  logic [8:0]  qw_in = 9'd0;
  logic [15:0] cid = 16'h0;
  logic [2:0]  mrrs = 3'd0;
  logic        tdst_rdy_n = 1'b0;
  logic        read_chunk_ack;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [63:0] mon_td[$];
  logic        mon_sof[$];
  logic        mon_eof[$];
  logic [7:0]  mon_rem[$];
  int          mon_cyc[$];
  int          ack_cyc[$];

  tx_rd_req_tlp_gen #(.TAG_WIDTH(5), .MAX_QW_CAP(64)) dut (
    .trn_clk                 (trn_clk),
    .reset_n                 (reset_n),
    .read_chunk              (read_chunk),
    .huge_page_addr_read_from(addr_in),
    .qwords_to_rd            (qw_in),
    .read_chunk_ack          (read_chunk_ack),
    .cfg_completer_id        (cid),
    .cfg_max_rd_req_size     (mrrs),
    .trn_td                  (trn_td),
    .trn_trem_n              (trn_trem_n),
    .trn_tsof_n              (trn_tsof_n),
    .trn_teof_n              (trn_teof_n),
    .trn_tsrc_rdy_n          (trn_tsrc_rdy_n),
    .trn_tsrc_dsc_n          (trn_tsrc_dsc_n),
    .trn_tdst_rdy_n          (tdst_rdy_n),
    .dbg_state               (dbg_state)
  );

  // Clock and cycle counter
  always #5 trn_clk = ~trn_clk;
  always @(posedge trn_clk) cyc <= cyc + 1;

  // Monitor: record accepted beats and ack pulses on the falling edge
  always @(negedge trn_clk) begin
    if (!trn_tsrc_rdy_n && !tdst_rdy_n) begin
      mon_td.push_back(trn_td);
      mon_sof.push_back(trn_tsof_n);
      mon_eof.push_back(trn_teof_n);
      mon_rem.push_back(trn_trem_n);
      mon_cyc.push_back(cyc);
    end
    if (read_chunk_ack) ack_cyc.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    mon_td.delete(); mon_sof.delete(); mon_eof.delete();
    mon_rem.delete(); mon_cyc.delete(); ack_cyc.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; read_chunk = 1'b0; tdst_rdy_n = 1'b0;
    repeat (3) @(posedge trn_clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic start_chunk(input logic [63:0] a, input logic [8:0] q, input logic [2:0] m,
                             output int s);
    @(posedge trn_clk); #1;
    clear_mon();
    addr_in = a; qw_in = q; mrrs = m; read_chunk = 1'b1;
    s = cyc;
  endtask

  task automatic wait_ack(input int bound, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge trn_clk);
      if (read_chunk_ack) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL %s_ack_wait: got no ack in %0d cycles, want ack", name, bound);
    else n_pass++;
    @(posedge trn_clk); #1 read_chunk = 1'b0;
    repeat (2) @(posedge trn_clk);
  endtask

  task automatic test_reset();
    @(negedge trn_clk);
    n_checks++; if (trn_td !== 64'h0) $display("FAIL rst_td: got %h want 0", trn_td); else n_pass++;
    n_checks++; if (trn_trem_n !== 8'h00) $display("FAIL rst_trem: got %h want 00", trn_trem_n); else n_pass++;
    n_checks++; if ({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n} !== 4'b1111)
      $display("FAIL rst_ctl: got %b want 1111", {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n});
    else n_pass++;
    n_checks++; if (read_chunk_ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", read_chunk_ack); else n_pass++;
    do_reset();
  endtask

  task automatic test_single_4dw();
    int s;
    do_reset();
    cid = 16'h0100;
    start_chunk(64'h0000_0001_2345_6000, 9'd64, 3'd2, s);
    // Inputs change after the request is latched and must be ignored
    @(posedge trn_clk); #1 addr_in = 64'hFFFF_FFFF_FFFF_FFFF; qw_in = 9'd3; mrrs = 3'd0;
    wait_ack(20, "single");
    n_checks++; if (mon_td.size() != 2) $display("FAIL single_beats: got %0d want 2", mon_td.size()); else n_pass++;
    n_checks++; if (mon_td[0] !== 64'h20000080_010000FF) $display("FAIL single_qw0: got %h want 20000080010000ff", mon_td[0]); else n_pass++;
    n_checks++; if ({mon_sof[0], mon_eof[0]} !== 2'b01) $display("FAIL single_sof0: got %b want 01", {mon_sof[0], mon_eof[0]}); else n_pass++;
    n_checks++; if (mon_td[1] !== 64'h00000001_23456000) $display("FAIL single_qw1: got %h want 0000000123456000", mon_td[1]); else n_pass++;
    n_checks++; if ({mon_sof[1], mon_eof[1]} !== 2'b10) $display("FAIL single_eof1: got %b want 10", {mon_sof[1], mon_eof[1]}); else n_pass++;
    n_checks++; if (mon_rem[1] !== 8'h00) $display("FAIL single_trem: got %h want 00", mon_rem[1]); else n_pass++;
    n_checks++; if (mon_cyc[0] != s + 2) $display("FAIL single_sof_lat: got %0d want %0d", mon_cyc[0], s + 2); else n_pass++;
    n_checks++; if (ack_cyc.size() != 1) $display("FAIL single_ack_cnt: got %0d want 1", ack_cyc.size()); else n_pass++;
    n_checks++; if (ack_cyc[0] != mon_cyc[1] + 1) $display("FAIL single_ack_lat: got %0d want %0d", ack_cyc[0], mon_cyc[1] + 1); else n_pass++;
  endtask

  task automatic test_multi_3dw();
    int s;
    logic [63:0] e;
    do_reset();
    cid = 16'h0100;
    start_chunk(64'h0000_0000_4000_0000, 9'd64, 3'd0, s);
    wait_ack(40, "multi");
    n_checks++; if (mon_td.size() != 8) $display("FAIL multi_beats: got %0d want 8", mon_td.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      e = {32'h00000020, 16'h0100, 8'(i), 8'hFF};
      n_checks++; if (mon_td[2*i] !== e) $display("FAIL multi_hdr%0d: got %h want %h", i, mon_td[2*i], e); else n_pass++;
      e = {32'h40000000 + 32'(i * 128), 32'h0};
      n_checks++; if (mon_td[2*i+1] !== e) $display("FAIL multi_addr%0d: got %h want %h", i, mon_td[2*i+1], e); else n_pass++;
      n_checks++; if (mon_rem[2*i+1] !== 8'h0F) $display("FAIL multi_trem%0d: got %h want 0f", i, mon_rem[2*i+1]); else n_pass++;
      if (i < 3) begin
        n_checks++; if (mon_cyc[2*i+2] != mon_cyc[2*i+1] + 2)
          $display("FAIL multi_gap%0d: got %0d want %0d", i, mon_cyc[2*i+2], mon_cyc[2*i+1] + 2);
        else n_pass++;
      end
    end
    n_checks++; if (ack_cyc.size() != 1) $display("FAIL multi_ack_cnt: got %0d want 1", ack_cyc.size()); else n_pass++;
    n_checks++; if (ack_cyc[0] != mon_cyc[7] + 1) $display("FAIL multi_ack_lat: got %0d want %0d", ack_cyc[0], mon_cyc[7] + 1); else n_pass++;
  endtask

  task automatic test_4k_split();
    int s;
    do_reset();
    cid = 16'h0100;
    start_chunk(64'h0000_0000_8000_0F00, 9'd64, 3'd2, s);
    wait_ack(30, "split");
    n_checks++; if (mon_td.size() != 4) $display("FAIL split_beats: got %0d want 4", mon_td.size()); else n_pass++;
    n_checks++; if (mon_td[0] !== 64'h00000040_010000FF) $display("FAIL split_hdr0: got %h want 00000040010000ff", mon_td[0]); else n_pass++;
    n_checks++; if (mon_td[1] !== 64'h80000F00_00000000) $display("FAIL split_addr0: got %h want 80000f0000000000", mon_td[1]); else n_pass++;
    n_checks++; if (mon_td[2] !== 64'h00000040_010001FF) $display("FAIL split_hdr1: got %h want 00000040010001ff", mon_td[2]); else n_pass++;
    n_checks++; if (mon_td[3] !== 64'h80001000_00000000) $display("FAIL split_addr1: got %h want 8000100000000000", mon_td[3]); else n_pass++;
  endtask

  task automatic test_mrrs_cap();
    int s;
    do_reset();
    cid = 16'h0100;
    start_chunk(64'h0, 9'd100, 3'd5, s);
    wait_ack(30, "cap");
    n_checks++; if (mon_td.size() != 4) $display("FAIL cap_beats: got %0d want 4", mon_td.size()); else n_pass++;
    n_checks++; if (mon_td[0] !== 64'h00000080_010000FF) $display("FAIL cap_hdr0: got %h want 00000080010000ff", mon_td[0]); else n_pass++;
    n_checks++; if (mon_td[1] !== 64'h00000000_00000000) $display("FAIL cap_addr0: got %h want 0", mon_td[1]); else n_pass++;
    n_checks++; if (mon_td[2] !== 64'h00000048_010001FF) $display("FAIL cap_hdr1: got %h want 00000048010001ff", mon_td[2]); else n_pass++;
    n_checks++; if (mon_td[3] !== 64'h00000200_00000000) $display("FAIL cap_addr1: got %h want 0000020000000000", mon_td[3]); else n_pass++;
  endtask

  task automatic test_backpressure();
    int s;
    bit found, stable;
    logic [74:0] h;
    do_reset();
    cid = 16'h0100;
    tdst_rdy_n = 1'b1;
    start_chunk(64'h0000_0000_0000_2000, 9'd8, 3'd2, s);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge trn_clk);
      if (!trn_tsrc_rdy_n) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL bp_hdr0_seen: got none want sof"); else n_pass++;
    h = {trn_td, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_trem_n};
    n_checks++; if (h !== {64'h00000010_010000FF, 3'b010, 8'h00}) $display("FAIL bp_hdr0_val: got %h want %h", h, {64'h00000010_010000FF, 3'b010, 8'h00}); else n_pass++;
    stable = 1'b1;
    repeat (5) begin
      @(negedge trn_clk);
      if ({trn_td, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_trem_n} !== h) stable = 1'b0;
    end
    n_checks++; if (!stable) $display("FAIL bp_hdr0_hold: got change want stable"); else n_pass++;
    @(posedge trn_clk); #1 tdst_rdy_n = 1'b0;
    @(posedge trn_clk); #1 tdst_rdy_n = 1'b1;
    @(negedge trn_clk);
    h = {trn_td, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_trem_n};
    n_checks++; if (h !== {64'h00002000_00000000, 3'b100, 8'h0F}) $display("FAIL bp_hdr1_val: got %h want %h", h, {64'h00002000_00000000, 3'b100, 8'h0F}); else n_pass++;
    stable = 1'b1;
    repeat (5) begin
      @(negedge trn_clk);
      if ({trn_td, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_trem_n} !== h) stable = 1'b0;
    end
    n_checks++; if (!stable) $display("FAIL bp_hdr1_hold: got change want stable"); else n_pass++;
    @(posedge trn_clk); #1 tdst_rdy_n = 1'b0;
    wait_ack(10, "bp");
    n_checks++; if (mon_td.size() != 2) $display("FAIL bp_beats: got %0d want 2", mon_td.size()); else n_pass++;
  endtask

  task automatic test_zero_len();
    int s;
    bit seen;
    do_reset();
    start_chunk(64'h0000_0000_0000_1000, 9'd0, 3'd0, s);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge trn_clk);
      if (read_chunk_ack) seen = 1'b1;
    end
    repeat (10) @(negedge trn_clk);
    @(posedge trn_clk); #1 read_chunk = 1'b0;
    repeat (2) @(posedge trn_clk);
    n_checks++; if (ack_cyc.size() != 1) $display("FAIL zero_ack_cnt: got %0d want 1", ack_cyc.size()); else n_pass++;
    n_checks++; if (ack_cyc[0] != s + 1) $display("FAIL zero_ack_lat: got %0d want %0d", ack_cyc[0], s + 1); else n_pass++;
    n_checks++; if (mon_td.size() != 0) $display("FAIL zero_tx: got %0d beats want 0", mon_td.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s;
    logic [63:0] t;
    do_reset();
    cid = 16'h0100;
    start_chunk(64'h0000_0000_0001_0000, 9'd256, 3'd0, s);
    wait_ack(200, "b2b_a");
    n_checks++; if (mon_td.size() != 32) $display("FAIL b2b_a_beats: got %0d want 32", mon_td.size()); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      t = mon_td[2*i];
      n_checks++; if (t[15:8] !== 8'(i)) $display("FAIL b2b_a_tag%0d: got %h want %h", i, t[15:8], 8'(i)); else n_pass++;
      t = mon_td[2*i+1];
      n_checks++; if (t[63:32] !== 32'h00010000 + 32'(i * 128)) $display("FAIL b2b_a_addr%0d: got %h want %h", i, t[63:32], 32'h00010000 + 32'(i * 128)); else n_pass++;
    end
    start_chunk(64'h0000_0000_0002_0000, 9'd272, 3'd0, s);
    wait_ack(200, "b2b_b");
    n_checks++; if (mon_td.size() != 34) $display("FAIL b2b_b_beats: got %0d want 34", mon_td.size()); else n_pass++;
    for (int i = 0; i < 17; i++) begin
      t = mon_td[2*i];
      n_checks++; if (t[15:8] !== 8'((16 + i) % 32)) $display("FAIL b2b_b_tag%0d: got %h want %h", i, t[15:8], 8'((16 + i) % 32)); else n_pass++;
      t = mon_td[2*i+1];
      n_checks++; if (t[63:32] !== 32'h00020000 + 32'(i * 128)) $display("FAIL b2b_b_addr%0d: got %h want %h", i, t[63:32], 32'h00020000 + 32'(i * 128)); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_tlp();
    int s, n_eof;
    logic [63:0] t;
    do_reset();
    cid = 16'h0100;
    start_chunk(64'h0000_0000_4000_0000, 9'd64, 3'd0, s);
    n_eof = 0;
    for (int k = 0; k < 30 && n_eof < 2; k++) begin
      @(negedge trn_clk);
      if (!trn_teof_n && !trn_tsrc_rdy_n) n_eof++;
    end
    n_checks++; if (n_eof != 2) $display("FAIL rmid_reach: got %0d eofs want 2", n_eof); else n_pass++;
    #1 reset_n = 1'b0; read_chunk = 1'b0;
    @(negedge trn_clk);
    n_checks++; if ({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n} !== 4'b1111)
      $display("FAIL rmid_ctl: got %b want 1111", {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n});
    else n_pass++;
    n_checks++; if (trn_td !== 64'h0) $display("FAIL rmid_td: got %h want 0", trn_td); else n_pass++;
    n_checks++; if (trn_trem_n !== 8'h00) $display("FAIL rmid_trem: got %h want 00", trn_trem_n); else n_pass++;
    repeat (2) @(posedge trn_clk);
    #1 reset_n = 1'b1;
    start_chunk(64'h0000_0000_5000_0000, 9'd16, 3'd0, s);
    wait_ack(20, "rmid");
    n_checks++; if (mon_td.size() != 2) $display("FAIL rmid_beats: got %0d want 2", mon_td.size()); else n_pass++;
    t = mon_td[0];
    n_checks++; if (t[15:8] !== 8'h00) $display("FAIL rmid_tag: got %h want 00", t[15:8]); else n_pass++;
    n_checks++; if (mon_td[1] !== 64'h50000000_00000000) $display("FAIL rmid_addr: got %h want 5000000000000000", mon_td[1]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_4dw();
    test_multi_3dw();
    test_4k_split();
    test_mrrs_cap();
    test_backpressure();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_tlp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
